// File: rtl/vga_pkg.sv
// Purpose: shared timing constants, pixel geometry and port-owner encoding for the VGA fetch path.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package vga_pkg;

    // Display timing, in clocks and lines, as produced by the vga counter block.
    localparam int H_ACTIVE = 800;
    localparam int H_TOTAL  = 1040;
    localparam int V_ACTIVE = 600;
    localparam int V_TOTAL  = 666;

    // One memory word carries one group of 16 pixels at 3 bits (RGB) each.
    localparam int GRP_W    = 16;
    localparam int BPP      = 3;
    localparam int PIX_W    = GRP_W * BPP;

    // Group counts derived from the timing above.
    localparam int H_GROUPS_ACTIVE = H_ACTIVE / GRP_W;
    localparam int H_GROUPS_TOTAL  = H_TOTAL / GRP_W;

    // Who owns the frame memory port in a given cycle.
    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_WR   = 2'd2
    } owner_t;

    // Position of a horizontal count within its 16-clock group.
    function automatic logic [3:0] grp_phase(input logic [10:0] x);
        return x[3:0];
    endfunction

endpackage

// File: rtl/vga_fetch_addr.sv
// Purpose: maps the current beam position to the memory word of the NEXT 16-pixel group, with line/frame wrap.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   cnt_X, cnt_Y  current horizontal / vertical count
//   addr          {line[9:ROW_SHIFT], column[5:0]} of the next group
//   visible       next group lies inside the active picture
module vga_fetch_addr
    import vga_pkg::*;
#(
    parameter int ROW_SHIFT = 2,
    parameter int ADDR_W    = (10 - ROW_SHIFT) + 6
) (
    input  logic [10:0]       cnt_X,
    input  logic [9:0]        cnt_Y,
    output logic [ADDR_W-1:0] addr,
    output logic              visible
);

    logic [7:0] grp_next;
    logic [7:0] col;
    logic [9:0] ln;

    always_comb begin
        // Index of the group that starts after the current one. Forcing the
        // low nibble to 15 before incrementing rounds up to the next boundary.
        grp_next = 8'(({1'b0, cnt_X} | 12'h00F) + 12'd1 >> 4);

        if (grp_next == 8'(H_GROUPS_TOTAL)) begin
            // Next group is the first one of the following line.
            col = 8'd0;
            ln  = (cnt_Y == 10'(V_TOTAL - 1)) ? 10'd0 : cnt_Y + 10'd1;
        end else begin
            col = grp_next;
            ln  = cnt_Y;
        end

        visible = (col < 8'(H_GROUPS_ACTIVE)) && (ln < 10'(V_ACTIVE));
        addr    = {ln[9:ROW_SHIFT], col[5:0]};
    end

endmodule

// File: rtl/vga_fetch_arb.sv
// Purpose: time-shares the single-port frame memory between display fetch and the game writer; sequences pixels.
// Latency: read issued at phase FETCH_PHASE, captured one clock later, presented at phase 0 of the next group.
// Backpressure: writer holds wr_req until wr_ack; it loses at most the one display slot per 16-clock group.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   cnt_X, cnt_Y        beam position from the vga block (all sequencing derives from these)
//   pixels              48-bit word for the current 16-pixel group, stable for the whole group
//   mem_addr/we/wdata   frame memory port; mem_rdata returns one clock after the address
//   wr_req/addr/data    writer request, held until acknowledged
//   wr_ack              asserted in exactly the cycle the write is driven onto the port
module vga_fetch_arb
    import vga_pkg::*;
#(
    parameter int ROW_SHIFT   = 2,
    parameter int ADDR_W      = (10 - ROW_SHIFT) + 6,
    parameter int FETCH_PHASE = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [10:0]       cnt_X,
    input  logic [9:0]        cnt_Y,
    output logic [47:0]       pixels,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [47:0]       mem_wdata,
    input  logic [47:0]       mem_rdata,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [47:0]       wr_data,
    output logic              wr_ack
);

    owner_t            owner;
    owner_t            owner_nxt;

    logic [ADDR_W-1:0] tgt_addr;
    logic              tgt_vis;
    logic              pre_slot;

    logic [ADDR_W-1:0] disp_addr;
    logic [ADDR_W-1:0] hold_addr;
    logic [47:0]       hold_wdata;
    logic [47:0]       shadow;
    logic              fetch_pend;
    logic              blank_pend;
    logic              rd_done;

    vga_fetch_addr #(
        .ROW_SHIFT (ROW_SHIFT),
        .ADDR_W    (ADDR_W)
    ) u_fetch_addr (
        .cnt_X   (cnt_X),
        .cnt_Y   (cnt_Y),
        .addr    (tgt_addr),
        .visible (tgt_vis)
    );

    // The cycle before the display slot: ownership for the next cycle is
    // decided here and registered, so the port mux sees a clean flop.
    assign pre_slot = (grp_phase(cnt_X) == 4'(FETCH_PHASE - 1));

    // ------------------------------------------------------------------
    // Port-owner state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= OWN_IDLE;
        end else begin
            owner <= owner_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next owner: display only when the upcoming group is on screen;
    // an off-screen group donates its slot to the writer.
    // ------------------------------------------------------------------
    always_comb begin
        owner_nxt = OWN_WR;
        if (pre_slot && tgt_vis) begin
            owner_nxt = OWN_DISP;
        end
    end

    // ------------------------------------------------------------------
    // Port outputs. The writer is served combinationally inside its slot so
    // a held request sees its ack in the same cycle and can advance at the
    // next edge, giving back-to-back writes without duplicates.
    // ------------------------------------------------------------------
    always_comb begin
        mem_addr  = hold_addr;
        mem_we    = 1'b0;
        mem_wdata = hold_wdata;
        wr_ack    = 1'b0;
        case (owner)
            OWN_DISP: begin
                mem_addr = disp_addr;
            end
            OWN_WR: begin
                if (wr_req) begin
                    mem_addr  = wr_addr;
                    mem_we    = 1'b1;
                    mem_wdata = wr_data;
                    wr_ack    = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Last driven address/data, so an idle writer slot leaves the port quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_addr  <= '0;
            hold_wdata <= '0;
        end else begin
            hold_addr  <= mem_addr;
            hold_wdata <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Fetch pipeline and pixel registers.
    //   phase FETCH_PHASE-1 : target latched, fetch_pend / blank_pend set
    //   phase FETCH_PHASE   : address on the port (display slot)
    //   phase FETCH_PHASE+1 : rd_done, read data captured into shadow
    //   phase 15            : shadow copied to pixels for the next group
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            disp_addr  <= '0;
            fetch_pend <= 1'b0;
            blank_pend <= 1'b0;
            rd_done    <= 1'b0;
            shadow     <= '0;
            pixels     <= '0;
        end else begin
            // Only a slot actually owned by the display counts as a read, so
            // a beam jump cannot leave a stale capture armed.
            rd_done    <= fetch_pend && (owner == OWN_DISP);
            blank_pend <= pre_slot && !tgt_vis;

            if (pre_slot) begin
                disp_addr <= tgt_addr;
            end

            if (rd_done) begin
                shadow     <= mem_rdata;
                fetch_pend <= 1'b0;
            end else if (blank_pend) begin
                shadow <= '0;
            end

            if (pre_slot && tgt_vis) begin
                fetch_pend <= 1'b1;
            end

            if (grp_phase(cnt_X) == 4'hF) begin
                pixels <= shadow;
            end
        end
    end

endmodule

// File: tb/tb_vga_fetch_arb.sv
// Purpose: randomized self-checking bench for vga_fetch_arb against a behavioural frame model.
// Latency: n/a.
// Backpressure: n/a.
module tb_vga_fetch_arb;
    import vga_pkg::*;

    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          rst;
    logic [10:0]   cnt_X;
    logic [9:0]    cnt_Y;
    logic [47:0]   pixels;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [47:0]   mem_wdata;
    logic [47:0]   mem_rdata;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [47:0]   wr_data;
    logic          wr_ack;

    always #10 clk = ~clk;

    vga_fetch_arb dut (
        .clk       (clk),
        .rst       (rst),
        .cnt_X     (cnt_X),
        .cnt_Y     (cnt_Y),
        .pixels    (pixels),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .wr_req    (wr_req),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .wr_ack    (wr_ack)
    );

    // Frame memory: single port, synchronous read, preloaded with word = address.
    logic [47:0] mem [0:(1<<AW)-1];
    logic        preload;

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 48'(i);
        end else if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
        end
        mem_rdata <= mem[mem_addr];
    end

    int          checks = 0;
    int          errors = 0;
    int          x, y;
    int          wmode;
    int          skip;
    int          ack_cnt;
    int          wr_k;
    bit          grp_vis;
    bit          acked;
    logic [47:0] exp_next;
    logic [47:0] exp_pix;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s x=%0d y=%0d got=%0h exp=%0h", tag, x, y, got, exp);
        end
    endtask

    // Writer behaviours: 1 = random held requests anywhere, 2 = continuous
    // incrementing writes into off-screen rows, 3 = single directed write.
    task automatic drive_writer();
        case (wmode)
            1: begin
                if (!wr_req || acked) begin
                    wr_req  = ($urandom_range(0, 1) == 1);
                    wr_addr = AW'($urandom());
                    wr_data = 48'({$urandom(), $urandom()});
                end
            end
            2: begin
                if (acked) wr_k++;
                wr_req  = 1'b1;
                wr_addr = AW'(14'h2800 + (wr_k % 2048));
                if (acked || wr_k == 0) wr_data = 48'({$urandom(), $urandom()});
            end
            default: begin
                wr_req  = (y == 8 && x == 75);
                wr_addr = 14'd133;
                wr_data = 48'hABCD_ABCD_ABCD;
            end
        endcase
    endtask

    task automatic observe();
        int ph, nx, ny, col, taddr;
        bit vis;
        ph = x % 16;
        if (rst) begin
            check("rst_pixels", 64'(pixels), 64'd0);
            check("rst_we", 64'(mem_we), 64'd0);
            check("rst_ack", 64'(wr_ack), 64'd0);
            check("rst_addr", 64'(mem_addr), 64'd0);
            check("rst_wdata", 64'(mem_wdata), 64'd0);
            acked = 1'b0;
            return;
        end
        acked = wr_ack;
        if (ph == 0) begin
            exp_pix = exp_next;
            if (skip > 0) skip--;
            ack_cnt = 0;
        end
        ack_cnt += int'(wr_ack);
        if (skip == 0) check("pixels", 64'(pixels), 64'(exp_pix));

        if (ph == 12) begin
            // Next group on the beam, straight from the frame geometry.
            nx = x - ph + 16;
            ny = y;
            if (nx >= H_TOTAL) begin
                nx = 0;
                ny = (y + 1) % V_TOTAL;
            end
            col     = nx / 16;
            vis     = (col < H_ACTIVE / 16) && (ny < V_ACTIVE);
            taddr   = (ny / 4) * 64 + col;
            grp_vis = vis;
            if (vis) begin
                exp_next = mem[taddr];
                if (skip == 0) begin
                    check("rd_addr", 64'(mem_addr), 64'(taddr));
                    check("rd_we", 64'(mem_we), 64'd0);
                    check("rd_no_ack", 64'(wr_ack), 64'd0);
                end
            end else begin
                exp_next = '0;
            end
        end

        if (ph == 15 && wmode == 2 && skip == 0)
            check("acks_per_grp", 64'(ack_cnt), grp_vis ? 64'd15 : 64'd16);

        if (wmode == 3) begin
            if (y == 8 && x == 75) check("dir_wr_ack", 64'(wr_ack), 64'd1);
            if (y >= 8 && y <= 11 && x == 85)
                check("dir_pix", 64'(pixels), 64'h0000_ABCD_ABCD_ABCD);
            if (y == 8 && ph == 8 && x < 800 && (x / 16) != 5)
                check("line8_pix", 64'(pixels), 64'((2 << 6) | (x / 16)));
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
        x++;
        if (x == H_TOTAL) begin
            x = 0;
            y = (y + 1) % V_TOTAL;
        end
        cnt_X = 11'(x);
        cnt_Y = 10'(y);
        preload = 1'b0;
        drive_writer();
        @(negedge clk);
        observe();
    endtask

    task automatic run_seg(input int y0, input int x0, input int mode, input int n);
        wmode = mode;
        skip  = 2;
        x     = x0 - 1;
        y     = y0;
        repeat (n) cycle();
    endtask

    initial begin
        rst      = 1'b1;
        preload  = 1'b1;
        x        = 959;
        y        = 665;
        cnt_X    = 11'(x);
        cnt_Y    = 10'(y);
        wmode    = 2;
        wr_k     = 0;
        acked    = 1'b0;
        wr_req   = 1'b1;
        wr_addr  = 14'h2800;
        wr_data  = 48'h1234_5678_9ABC;
        skip     = 2;
        ack_cnt  = 0;
        grp_vis  = 1'b0;
        exp_next = '0;
        exp_pix  = '0;

        // Reset held while the beam runs; writer requesting throughout.
        repeat (48) cycle();
        rst      = 1'b0;
        skip     = 1;
        exp_next = '0;
        exp_pix  = '0;
        repeat (32 + 2 * 1040) cycle();

        run_seg(7, 1000, 3, 40 + 5 * 1040);
        run_seg(10, 0, 1, 3 * 1040);
        run_seg(598, 1000, 2, 40 + 3 * 1040);
        run_seg(664, 900, 1, 140 + 3 * 1040);
        run_seg(100, 400, 2, 2000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_fetch_arb.md
Name: vga_fetch_arb

Overview:
- Sequences the 48-bit `pixels` word consumed by the `vga` timing/output block.
- Fetches one 16-pixel word (16 x 3-bit RGB) per 16-clock group from a single-port synchronous frame memory, one group ahead of the beam.
- Shares the same memory port with the game-logic writer, which gets every cycle not needed for display fetch.
- Replaces `siggen` between `vga` and the playfield memory.

Parameters:
- H_ACTIVE, 800, visible pixels per line (multiple of 16)
- H_TOTAL, 1040, clocks per line incl. blanking (multiple of 16)
- V_ACTIVE, 600, visible lines
- V_TOTAL, 666, lines per frame
- ROW_SHIFT, 2, log2 of display lines per memory row (pixel doubling)
- ADDR_W, 14, memory address width = (10-ROW_SHIFT)+6
- FETCH_PHASE, 12, cnt_X[3:0] value on which the display read is issued (0..13)

Ports:
- clk  in  1  50 MHz system clock
- rst  in  1  synchronous, active-high reset
- cnt_X  in  11  current horizontal count from `vga`
- cnt_Y  in  10  current vertical count from `vga`
- pixels  out  48  word for current 16-pixel group, to `vga`
- mem_addr  out  ADDR_W  frame memory address
- mem_we  out  1  frame memory write enable
- mem_wdata  out  48  frame memory write data
- mem_rdata  in  48  frame memory read data, valid 1 clk after address
- wr_req  in  1  writer request, held until acked
- wr_addr  in  ADDR_W  writer address
- wr_data  in  48  writer data
- wr_ack  out  1  1-clk pulse: write performed this cycle

Behaviour:
- One clock, `clk`. Reset `rst` is synchronous and active-high.
- Reset values: pixels=0, shadow=0, mem_we=0, mem_addr=0, mem_wdata=0, wr_ack=0, fetch_pend=0, blank_pend=0.
- Port ownership per cycle is registered, with a 1-cycle decision-to-port delay:
  - Cycle with cnt_X[3:0]==FETCH_PHASE-1 → next cycle is the display slot.
  - Otherwise the next cycle is the writer slot.
- Fetch target is computed when cnt_X[3:0]==FETCH_PHASE-1, for the group starting at xn = (cnt_X & ~15)+16:
  - If xn==H_TOTAL: col=0, ln=cnt_Y+1, wrapping to 0 when cnt_Y+1==V_TOTAL.
  - Else: col=xn>>4, ln=cnt_Y.
  - visible = (col < H_ACTIVE/16) && (ln < V_ACTIVE).
- Display slot:
  - If visible: mem_addr={ln[9:ROW_SHIFT], col[5:0]}, mem_we=0, fetch_pend=1.
  - If not visible: no read, blank_pend=1, and the slot is given to the writer instead.
- On the clock after a display read, shadow<=mem_rdata and fetch_pend clears. If blank_pend, shadow<=0.
- When cnt_X[3:0]==15, pixels<=shadow, so pixels is stable for all 16 clocks of the group.
- Display latency: read issued at phase FETCH_PHASE, data at FETCH_PHASE+1, presented at phase 0 of the next group.
- Writer slot with wr_req=1: mem_addr=wr_addr, mem_we=1, mem_wdata=wr_data, wr_ack=1 in the same cycle.
  - Back-to-back writes are allowed: wr_req still high after an ack is treated as a new request.
  - Writer slot with wr_req=0: mem_we=0, wr_ack=0, mem_addr holds.
- Collision: a wr_req arriving for a display slot waits exactly one cycle. wr_ack never coincides with a display read.
- Writer bandwidth ≥ 15/16 of cycles.
- Coherence: a write to the word being fetched, landing in the same cycle as the fetch, is impossible. A write in the slot before the fetch is seen by the fetch.
- cnt_X/cnt_Y jumps (vga reset):
  - Arbiter state is not corrupted.
  - The next group may show a stale word; correct from the following group.
- No internal counters are free-running. All sequencing derives from cnt_X/cnt_Y.

Decomposition:
- Shared package `vga_pkg` holds:
  - H_ACTIVE, H_TOTAL, V_ACTIVE, V_TOTAL.
  - Group width 16, bits per pixel 3.
  - Port-owner encoding: OWN_IDLE, OWN_DISP, OWN_WR.
- One sub-module: `vga_fetch_addr`, combinational. Maps (cnt_X, cnt_Y) → (addr, visible) with the line/frame wrap. Reusable by a future sprite overlay.
- Arbitration FSM and the shadow/pixels registers stay in `vga_fetch_arb`.

Test Plan:
- Reset held with cnt_X running → pixels=0, mem_we=0, wr_ack=0 throughout. After release, first visible group shows mem word 0 at cnt_X=0,cnt_Y=0.
- Memory preloaded with word=address. Sweep one visible line (cnt_Y=8) → pixels = {ln[9:2]=2, col} for col 0..49, each held 16 clks. Read at phase 12 only.
- cnt_X 784..1039 → no reads. pixels=0 during groups 50..64. At cnt_X=1036 (phase 12 of last group) the read targets line cnt_Y+1, col 0.
- cnt_Y=665 end of line → fetch targets ln=0 (address 0). cnt_Y 600..665 → no reads, pixels=0.
- wr_req held continuously with an incrementing address → 15 acks per visible 16-clk group, no ack at phase 12. 16 acks per group in blanking. Read data unaffected.
- Write 0xABCD… to address {2,5} one cycle before its fetch → pixels shows 0xABCD… for group col 5 of lines 8..11.
